// File: rtl/clk_enable_divider.sv
// Multi-channel clock-enable generator: each channel divides clk by a programmable
// divisor and emits a one-cycle enable (pulse mode) or a toggling level (toggle mode).
//
// state | meaning
// IDLE  | stopped; outputs low; active config tracks the shadow every cycle
// RUN   | counting; enable after count reaches div-1; shadow applied at wrap/resync
module clk_enable_divider #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 3,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              run,
  input  logic              resync,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_phase,
  input  logic              cfg_mode,
  output logic [NUM_CH-1:0] ce_out,
  output logic [NUM_CH-1:0] level_out,
  output logic [NUM_CH-1:0] busy
);

  localparam logic [0:0]       ST_IDLE = 1'b0;
  localparam logic [0:0]       ST_RUN  = 1'b1;
  localparam logic [CNT_W-1:0] ZERO    = '0;
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam logic [CH_W-1:0] CH_ID = CH_W'(g);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] sdiv_q, sdiv_d;
    logic [CNT_W-1:0] sphase_q, sphase_d;
    logic             smode_q, smode_d;
    logic             ce_q, ce_d;
    logic             level_q, level_d;

    logic             wr_hit;
    logic             at_term;
    logic [CNT_W-1:0] start_cnt;

    // Out-of-range cfg_ch values match no channel and are dropped.
    assign wr_hit    = cfg_wr && (cfg_ch == CH_ID);
    assign at_term   = (count_q == div_q - ONE);
    // Start/resync value from the shadow, clamped into the new period.
    assign start_cnt = (sphase_q >= sdiv_q) ? (sdiv_q - ONE) : sphase_q;

    always_comb begin
      sdiv_d   = wr_hit ? cfg_div   : sdiv_q;
      sphase_d = wr_hit ? cfg_phase : sphase_q;
      smode_d  = wr_hit ? cfg_mode  : smode_q;
      state_d  = state_q;
      count_d  = count_q;
      div_d    = div_q;
      mode_d   = mode_q;
      ce_d     = 1'b0;
      level_d  = 1'b0;

      if (state_q == ST_IDLE) begin
        div_d   = sdiv_q;
        mode_d  = smode_q;
        count_d = ZERO;
        if (run && (sdiv_q != ZERO)) begin
          state_d = ST_RUN;
          count_d = start_cnt;
          ce_d    = (start_cnt == sdiv_q - ONE);
          level_d = smode_q & ce_d;
        end
      end else if (!run || (div_q == ZERO)) begin
        state_d = ST_IDLE;
        count_d = ZERO;
      end else if (resync || at_term) begin
        // Period boundary: the shadow becomes active; resync takes priority over the wrap.
        div_d  = sdiv_q;
        mode_d = smode_q;
        if (sdiv_q == ZERO) begin
          state_d = ST_IDLE;
          count_d = ZERO;
        end else begin
          count_d = resync ? start_cnt : ZERO;
          ce_d    = (count_d == sdiv_q - ONE);
          level_d = smode_q & (resync ? ce_d : (level_q ^ ce_d));
        end
      end else begin
        count_d = count_q + ONE;
        ce_d    = (count_d == div_q - ONE);
        level_d = mode_q & (level_q ^ ce_d);
      end
    end

    always_ff @(posedge clk) begin
      if (RESET) begin
        state_q  <= ST_IDLE;
        count_q  <= ZERO;
        div_q    <= RST_DIV;
        mode_q   <= 1'b0;
        sdiv_q   <= RST_DIV;
        sphase_q <= ZERO;
        smode_q  <= 1'b0;
        ce_q     <= 1'b0;
        level_q  <= 1'b0;
      end else begin
        state_q  <= state_d;
        count_q  <= count_d;
        div_q    <= div_d;
        mode_q   <= mode_d;
        sdiv_q   <= sdiv_d;
        sphase_q <= sphase_d;
        smode_q  <= smode_d;
        ce_q     <= ce_d;
        level_q  <= level_d;
      end
    end

    assign ce_out[g]    = ce_q;
    assign level_out[g] = level_q;
    assign busy[g]      = (state_q == ST_RUN);
  end

endmodule

// File: tb/tb_clk_enable_divider.sv
// Bench for clk_enable_divider: directed scenarios plus random traffic, all checked
// cycle by cycle against a position-counting reference model of the enable rules.
module tb_clk_enable_divider;
  localparam int NCH = 2;
  localparam int CW  = 8;

  logic           clk = 1'b0;
  logic           RESET, run, resync, cfg_wr, cfg_mode;
  logic [0:0]     cfg_ch;
  logic [CW-1:0]  cfg_div, cfg_phase;
  logic [NCH-1:0] ce_out, level_out, busy;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: position within the period, active and shadow configs.
  int m_st[NCH], m_pos[NCH], m_div[NCH], m_md[NCH];
  int s_div[NCH], s_ph[NCH], s_md[NCH];
  bit m_ce[NCH], m_lvl[NCH];

  always #5 clk = ~clk;

  clk_enable_divider dut (
    .clk(clk), .RESET(RESET), .run(run), .resync(resync),
    .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .cfg_phase(cfg_phase), .cfg_mode(cfg_mode),
    .ce_out(ce_out), .level_out(level_out), .busy(busy)
  );

  function automatic int clampph(int ph, int dv);
    return (ph > dv - 1) ? dv - 1 : ph;
  endfunction

  function automatic logic [NCH-1:0] exp_ce();
    logic [NCH-1:0] r;
    for (int c = 0; c < NCH; c++) r[c] = m_ce[c];
    return r;
  endfunction

  function automatic logic [NCH-1:0] exp_lvl();
    logic [NCH-1:0] r;
    for (int c = 0; c < NCH; c++) r[c] = m_lvl[c];
    return r;
  endfunction

  function automatic logic [NCH-1:0] exp_busy();
    logic [NCH-1:0] r;
    for (int c = 0; c < NCH; c++) r[c] = (m_st[c] != 0);
    return r;
  endfunction

  task automatic m_stop(input int c);
    m_st[c] = 0; m_pos[c] = 0; m_ce[c] = 1'b0; m_lvl[c] = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic m_step();
    int od, op, om;
    for (int c = 0; c < NCH; c++) begin
      od = s_div[c]; op = s_ph[c]; om = s_md[c];
      if (RESET) begin
        m_stop(c);
        m_div[c] = 3; m_md[c] = 0; s_div[c] = 3; s_ph[c] = 0; s_md[c] = 0;
      end else begin
        if (m_st[c] == 0) begin
          m_div[c] = od; m_md[c] = om;
          m_stop(c);
          if (run && od != 0) begin
            m_st[c]  = 1;
            m_pos[c] = clampph(op, od);
            m_ce[c]  = (m_pos[c] == od - 1);
            m_lvl[c] = (om != 0) && m_ce[c];
          end
        end else if (!run) begin
          m_stop(c);
        end else if (resync) begin
          m_div[c] = od; m_md[c] = om;
          if (od == 0) m_stop(c);
          else begin
            m_pos[c] = clampph(op, od);
            m_ce[c]  = (m_pos[c] == od - 1);
            m_lvl[c] = (om != 0) && m_ce[c];
          end
        end else begin
          m_pos[c] = (m_pos[c] + 1) % m_div[c];
          if (m_pos[c] == 0) begin
            m_div[c] = od; m_md[c] = om;
          end
          if (m_div[c] == 0) m_stop(c);
          else begin
            m_ce[c]  = (m_pos[c] == m_div[c] - 1);
            m_lvl[c] = (m_md[c] != 0) && (m_lvl[c] ^ m_ce[c]);
          end
        end
        if (cfg_wr && int'(cfg_ch) == c) begin
          s_div[c] = int'(cfg_div); s_ph[c] = int'(cfg_phase); s_md[c] = int'(cfg_mode);
        end
      end
    end
  endtask

  task automatic advance();
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cfg(input int ch, input int dv, input int ph, input int md);
    cfg_wr = 1'b1; cfg_ch = 1'(ch); cfg_div = CW'(dv); cfg_phase = CW'(ph); cfg_mode = md[0];
    advance();
    cfg_wr = 1'b0;
  endtask

  task automatic test_reset();
    int first;
    RESET = 1'b1; run = 1'b1;
    for (int k = 0; k < 3; k++) begin
      advance();
      vectors++;
      if ({ce_out, level_out, busy} !== 6'b0)
        begin miscompares++; $display("FAIL reset_hold cyc %0d ce=%b lvl=%b busy=%b required all 0", k, ce_out, level_out, busy); end
    end
    RESET = 1'b0;
    first = -1;
    for (int k = 1; k <= 12; k++) begin
      advance();
      vectors++;
      if ({ce_out, level_out, busy} !== {exp_ce(), exp_lvl(), exp_busy()})
        begin miscompares++; $display("FAIL reset_release cyc %0d ce=%b lvl=%b busy=%b required ce=%b lvl=%b busy=%b", k, ce_out, level_out, busy, exp_ce(), exp_lvl(), exp_busy()); end
      if (first < 0 && ce_out[0] === 1'b1) first = k;
    end
    vectors++;
    if (first !== 3) begin miscompares++; $display("FAIL reset_first_ce got cycle %0d required 3", first); end
  endtask

  task automatic test_divisors();
    int f0, f1;
    run = 1'b0; advance(); advance();
    write_cfg(0, 5, 0, 0);
    write_cfg(1, 4, 3, 0);
    advance();
    run = 1'b1;
    f0 = -1; f1 = -1;
    for (int k = 1; k <= 30; k++) begin
      advance();
      vectors++;
      if ({ce_out, level_out, busy} !== {exp_ce(), exp_lvl(), exp_busy()})
        begin miscompares++; $display("FAIL divisors cyc %0d ce=%b lvl=%b busy=%b required ce=%b lvl=%b busy=%b", k, ce_out, level_out, busy, exp_ce(), exp_lvl(), exp_busy()); end
      if (f0 < 0 && ce_out[0] === 1'b1) f0 = k;
      if (f1 < 0 && ce_out[1] === 1'b1) f1 = k;
    end
    vectors++;
    if (f0 !== 5) begin miscompares++; $display("FAIL div5_first_ce got %0d required 5", f0); end
    vectors++;
    if (f1 !== 1) begin miscompares++; $display("FAIL phase3_first_ce got %0d required 1", f1); end
  endtask

  task automatic test_toggle();
    logic prev;
    int since, toggles;
    run = 1'b0; advance();
    write_cfg(1, 3, 0, 1);
    advance();
    run = 1'b1;
    prev = 1'b0; since = 0; toggles = 0;
    for (int k = 1; k <= 30; k++) begin
      advance();
      since++;
      vectors++;
      if ({ce_out, level_out, busy} !== {exp_ce(), exp_lvl(), exp_busy()})
        begin miscompares++; $display("FAIL toggle cyc %0d ce=%b lvl=%b busy=%b required ce=%b lvl=%b busy=%b", k, ce_out, level_out, busy, exp_ce(), exp_lvl(), exp_busy()); end
      if (level_out[1] !== prev) begin
        vectors++;
        if (ce_out[1] !== 1'b1) begin miscompares++; $display("FAIL toggle_ce_align cyc %0d ce=%b required 1", k, ce_out[1]); end
        if (toggles > 0) begin
          vectors++;
          if (since !== 3) begin miscompares++; $display("FAIL toggle_halfperiod got %0d required 3", since); end
        end
        toggles++; since = 0; prev = level_out[1];
      end
    end
    vectors++;
    if (toggles < 8) begin miscompares++; $display("FAIL toggle_count got %0d required >=8", toggles); end
  endtask

  task automatic test_midrun();
    bit found;
    int last, n;
    int gaps[3];
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      advance();
      vectors++;
      if ({ce_out, level_out, busy} !== {exp_ce(), exp_lvl(), exp_busy()})
        begin miscompares++; $display("FAIL midrun_wait cyc %0d ce=%b lvl=%b busy=%b required ce=%b lvl=%b busy=%b", k, ce_out, level_out, busy, exp_ce(), exp_lvl(), exp_busy()); end
      if (ce_out[0] === 1'b1) found = 1'b1;
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL midrun_timeout ce=%b required an enable", ce_out); end
    last = 0; n = 0;
    for (int t = 1; t <= 12; t++) begin
      if (t == 3) begin
        cfg_wr = 1'b1; cfg_ch = 1'b0; cfg_div = 8'd2; cfg_phase = 8'd0; cfg_mode = 1'b0;
      end
      advance();
      cfg_wr = 1'b0;
      vectors++;
      if ({ce_out, level_out, busy} !== {exp_ce(), exp_lvl(), exp_busy()})
        begin miscompares++; $display("FAIL midrun t %0d ce=%b lvl=%b busy=%b required ce=%b lvl=%b busy=%b", t, ce_out, level_out, busy, exp_ce(), exp_lvl(), exp_busy()); end
      if (ce_out[0] === 1'b1 && n < 3) begin gaps[n] = t - last; last = t; n++; end
    end
    vectors++;
    if (gaps[0] !== 5) begin miscompares++; $display("FAIL midrun_old_period got %0d required 5", gaps[0]); end
    vectors++;
    if (gaps[1] !== 2 || gaps[2] !== 2) begin miscompares++; $display("FAIL midrun_new_period got %0d,%0d required 2,2", gaps[1], gaps[2]); end
  endtask

  task automatic test_resync();
    int f0, f1;
    bit found;
    write_cfg(0, 4, 0, 0);
    write_cfg(1, 6, 0, 0);
    for (int k = 0; k < 16 + int'($urandom_range(0, 5)); k++) begin
      advance();
      vectors++;
      if ({ce_out, level_out, busy} !== {exp_ce(), exp_lvl(), exp_busy()})
        begin miscompares++; $display("FAIL resync_settle cyc %0d ce=%b lvl=%b busy=%b required ce=%b lvl=%b busy=%b", k, ce_out, level_out, busy, exp_ce(), exp_lvl(), exp_busy()); end
    end
    resync = 1'b1; advance(); resync = 1'b0;
    vectors++;
    if (ce_out !== 2'b00 || busy !== 2'b11) begin miscompares++; $display("FAIL resync_edge ce=%b busy=%b required ce=00 busy=11", ce_out, busy); end
    f0 = -1; f1 = -1;
    for (int k = 1; k <= 8; k++) begin
      advance();
      vectors++;
      if ({ce_out, level_out, busy} !== {exp_ce(), exp_lvl(), exp_busy()})
        begin miscompares++; $display("FAIL resync cyc %0d ce=%b lvl=%b busy=%b required ce=%b lvl=%b busy=%b", k, ce_out, level_out, busy, exp_ce(), exp_lvl(), exp_busy()); end
      if (f0 < 0 && ce_out[0] === 1'b1) f0 = k;
      if (f1 < 0 && ce_out[1] === 1'b1) f1 = k;
    end
    vectors++;
    if (f0 !== 3 || f1 !== 5) begin miscompares++; $display("FAIL resync_align got %0d,%0d required 3,5", f0, f1); end
    // Resync on ch0's wrap edge with phase 2: next enable must follow the phase, not the wrap.
    write_cfg(0, 4, 2, 0);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      advance();
      if (k > 4 && ce_out[0] === 1'b1) found = 1'b1;
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL resync_wrap_timeout ce=%b required an enable", ce_out); end
    resync = 1'b1; advance(); resync = 1'b0;
    vectors++;
    if (ce_out[0] !== 1'b0) begin miscompares++; $display("FAIL resync_wrap_suppress ce0=%b required 0", ce_out[0]); end
    advance();
    vectors++;
    if ({ce_out, level_out, busy} !== {exp_ce(), exp_lvl(), exp_busy()} || ce_out[0] !== 1'b1)
      begin miscompares++; $display("FAIL resync_wrap_phase ce=%b lvl=%b busy=%b required ce=%b (ce0=1) lvl=%b busy=%b", ce_out, level_out, busy, exp_ce(), exp_lvl(), exp_busy()); end
  endtask

  task automatic test_edge();
    logic prev_busy, prev_ce;
    bit fell;
    int first;
    vectors++;
    if (busy[1] !== 1'b1) begin miscompares++; $display("FAIL edge_ch1_running busy=%b required 1", busy[1]); end
    prev_busy = busy[1]; prev_ce = ce_out[1];
    write_cfg(1, 0, 0, 0);
    fell = 1'b0;
    for (int k = 0; k < 15; k++) begin
      if (busy[1] === 1'b0 && prev_busy === 1'b1) begin
        fell = 1'b1;
        vectors++;
        if (prev_ce !== 1'b1) begin miscompares++; $display("FAIL div0_at_wrap prev_ce=%b required 1", prev_ce); end
      end
      prev_busy = busy[1]; prev_ce = ce_out[1];
      advance();
      vectors++;
      if ({ce_out, level_out, busy} !== {exp_ce(), exp_lvl(), exp_busy()})
        begin miscompares++; $display("FAIL div0 cyc %0d ce=%b lvl=%b busy=%b required ce=%b lvl=%b busy=%b", k, ce_out, level_out, busy, exp_ce(), exp_lvl(), exp_busy()); end
    end
    vectors++;
    if (!fell || busy[1] !== 1'b0) begin miscompares++; $display("FAIL div0_idle busy1=%b fell=%0d required busy1=0 fell=1", busy[1], fell); end
    write_cfg(0, 1, 0, 0);
    for (int k = 0; k < 6; k++) advance();
    for (int k = 0; k < 10; k++) begin
      advance();
      vectors++;
      if (ce_out[0] !== 1'b1 || busy[0] !== 1'b1) begin miscompares++; $display("FAIL div1_const cyc %0d ce0=%b busy0=%b required 1,1", k, ce_out[0], busy[0]); end
    end
    RESET = 1'b1; advance(); RESET = 1'b0;
    vectors++;
    if ({ce_out, level_out, busy} !== 6'b0) begin miscompares++; $display("FAIL reset_mid ce=%b lvl=%b busy=%b required all 0", ce_out, level_out, busy); end
    first = -1;
    for (int k = 1; k <= 8; k++) begin
      advance();
      if (first < 0 && ce_out[0] === 1'b1) first = k;
    end
    vectors++;
    if (first !== 3) begin miscompares++; $display("FAIL reset_mid_default got %0d required 3", first); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 2000; k++) begin
      RESET  = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 59) == 0) run = ~run;
      resync = ($urandom_range(0, 39) == 0);
      cfg_wr = ($urandom_range(0, 7) == 0);
      cfg_ch = 1'($urandom_range(0, 1));
      cfg_div   = ($urandom_range(0, 9) == 0) ? 8'd1 : CW'($urandom_range(0, 7));
      cfg_phase = CW'($urandom_range(0, 9));
      cfg_mode  = 1'($urandom_range(0, 1));
      advance();
      vectors++;
      if ({ce_out, level_out, busy} !== {exp_ce(), exp_lvl(), exp_busy()})
        begin miscompares++; $display("FAIL random cyc %0d ce=%b lvl=%b busy=%b required ce=%b lvl=%b busy=%b", k, ce_out, level_out, busy, exp_ce(), exp_lvl(), exp_busy()); end
    end
    RESET = 1'b0; resync = 1'b0; cfg_wr = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; run = 1'b0; resync = 1'b0; cfg_wr = 1'b0;
    cfg_ch = 1'b0; cfg_div = '0; cfg_phase = '0; cfg_mode = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      m_stop(c);
      m_div[c] = 3; m_md[c] = 0; s_div[c] = 3; s_ph[c] = 0; s_md[c] = 0;
    end
    test_reset();
    test_divisors();
    test_toggle();
    test_midrun();
    test_resync();
    test_edge();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
